// File: rtl/mod_key_sched.sv
// Round-key sequencer: walks a key ROM from first to last index (or the reverse
// for decryption) and presents each key to a consumer over a valid/ready handshake.
module mod_key_sched #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 4,
  parameter int LAST_IDX = 14
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              decrypt,
  input  logic              abort,
  output logic              rom_start,
  output logic              rom_wr_en,
  output logic [ADDR_W-1:0] rom_sel,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              rom_done,
  output logic [DATA_W-1:0] key_out,
  output logic [ADDR_W-1:0] key_round,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              busy,
  output logic              seq_done
);

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(LAST_IDX);
  localparam logic [ADDR_W-1:0] IDX_ZERO = '0;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              r_dec;
  logic              w_dec_nxt;
  logic              w_capture;
  logic              w_is_last;
  logic [DATA_W-1:0] r_key;
  logic [ADDR_W-1:0] r_round;

  // Index arithmetic stays ADDR_W wide so the step wraps naturally.
  function automatic logic [ADDR_W-1:0] step_idx(input logic [ADDR_W-1:0] idx,
                                                 input logic              dec);
    return dec ? (idx - IDX_ONE) : (idx + IDX_ONE);
  endfunction

  assign w_is_last = r_dec ? (r_idx == IDX_ZERO) : (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dec_nxt   = r_dec;
    w_capture   = 1'b0;
    rom_start   = 1'b0;
    rom_wr_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_dec_nxt   = decrypt;
          w_idx_nxt   = decrypt ? IDX_LAST : IDX_ZERO;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        rom_start   = 1'b1;
        rom_wr_en   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rom_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (key_ready) begin
          if (w_is_last) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_idx_nxt   = step_idx(r_idx, r_dec);
            w_state_nxt = S_REQ;
          end
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Abort overrides every transition and freezes the datapath as it stands.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = r_idx;
      w_dec_nxt   = r_dec;
      w_capture   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx   <= '0;
      r_dec   <= 1'b0;
      r_key   <= '0;
      r_round <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      r_dec <= w_dec_nxt;
      if (w_capture) begin
        r_key   <= rom_data;
        r_round <= r_idx;
      end
    end
  end

  // idx only moves on entry to REQ, so it doubles as the held ROM select.
  assign rom_sel   = r_idx;
  assign key_out   = r_key;
  assign key_round = r_round;
  assign key_valid = (r_state == S_PRESENT);
  assign busy      = (r_state != S_IDLE);
  assign seq_done  = (r_state == S_FINISH);

endmodule

// File: tb/tb_mod_key_sched.sv
// Directed bench for mod_key_sched: ROM responder model, handshake monitor and
// cycle-exact checks of ordering, latency, backpressure, stalls, abort and reset.
module tb_mod_key_sched;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic         decrypt;
  logic         abort;
  logic         rom_start;
  logic         rom_wr_en;
  logic [3:0]   rom_sel;
  logic [127:0] rom_data;
  logic         rom_done;
  logic [127:0] key_out;
  logic [3:0]   key_round;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         seq_done;

  int n_chk = 0;
  int n_err = 0;
  int c     = 0;

  int           rom_dly  = 1;
  int           pend     = 0;
  logic [3:0]   pend_sel = '0;
  int           n_rs     = 0;
  int           n_done   = 0;
  int           q_round[$];
  logic [127:0] q_key[$];

  localparam logic [127:0] JUNK_IDLE  = {32{4'hA}};
  localparam logic [127:0] JUNK_SPUR  = {32{4'h5}};

  mod_key_sched #(.DATA_W(128), .ADDR_W(4), .LAST_IDX(14)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .decrypt   (decrypt),
    .abort     (abort),
    .rom_start (rom_start),
    .rom_wr_en (rom_wr_en),
    .rom_sel   (rom_sel),
    .rom_data  (rom_data),
    .rom_done  (rom_done),
    .key_out   (key_out),
    .key_round (key_round),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .seq_done  (seq_done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rom_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {16{b}};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, c, got, exp);
    end
  endtask

  // Monitor: strobes, handshakes and done pulses, observed mid-cycle.
  always @(negedge clk) begin
    if (rom_start === 1'b1) begin
      pend     = rom_dly;
      pend_sel = rom_sel;
      n_rs++;
    end
    if (key_valid === 1'b1 && key_ready === 1'b1) begin
      q_round.push_back(int'(key_round));
      q_key.push_back(key_out);
    end
    if (seq_done === 1'b1) n_done++;
  end

  // ROM responder: data-valid arrives rom_dly cycles after the strobe.
  always @(posedge clk) begin
    #1;
    rom_done = 1'b0;
    rom_data = JUNK_IDLE;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        rom_done = 1'b1;
        rom_data = rom_word(int'(pend_sel));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic start_seq(input logic dec);
    @(posedge clk);
    #1;
    start   = 1'b1;
    decrypt = dec;
    @(posedge clk);
    #1;
    start = 1'b0;
    c     = 1;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 300; i++) begin
      if (n_done != base) break;
      step();
    end
    check("seq_done_count", 128'(n_done - base), 128'(1));
  endtask

  task automatic check_queue(input logic dec);
    check("hs_count", 128'(q_round.size()), 128'(15));
    for (int i = 0; i < q_round.size() && i < 15; i++) begin
      check("hs_round", 128'(q_round[i]), 128'(dec ? 14 - i : i));
      check("hs_key", q_key[i], rom_word(dec ? 14 - i : i));
    end
  endtask

  task automatic run_full(input logic dec, input logic glitch);
    int  base_rs;
    int  base_done;
    int  k;
    bit  exp_v;
    bit  exp_rs;
    q_round.delete();
    q_key.delete();
    base_rs   = n_rs;
    base_done = n_done;
    start_seq(dec);
    while (c <= 47) begin
      if (glitch) begin
        start = (c == 5 || c == 20);
        if (c >= 5) decrypt = ~dec;
      end
      samp();
      exp_v  = (c % 3 == 0) && (c >= 3) && (c <= 45);
      exp_rs = (c % 3 == 1) && (c <= 43);
      k      = c / 3 - 1;
      check("key_valid", 128'(key_valid), 128'(exp_v));
      if (exp_v) begin
        check("key_round", 128'(key_round), 128'(dec ? 14 - k : k));
        check("key_out", key_out, rom_word(dec ? 14 - k : k));
      end
      check("rom_start", 128'(rom_start), 128'(exp_rs));
      check("rom_wr_en", 128'(rom_wr_en), 128'(exp_rs));
      if (exp_rs) check("rom_sel", 128'(rom_sel), 128'(dec ? 14 - c / 3 : c / 3));
      check("seq_done", 128'(seq_done), 128'(c == 46));
      check("busy", 128'(busy), 128'(c <= 46));
      step();
    end
    start   = 1'b0;
    decrypt = 1'b0;
    check("rom_strobes", 128'(n_rs - base_rs), 128'(15));
    check("done_pulses", 128'(n_done - base_done), 128'(1));
    check_queue(dec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_rs;
    int base_done;
    int rs9;
    resetn    = 1'b1;
    start     = 1'b0;
    decrypt   = 1'b0;
    abort     = 1'b0;
    key_ready = 1'b1;
    rom_done  = 1'b0;
    rom_data  = '0;
    #1 resetn = 1'b0;
    #2;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_key_valid", 128'(key_valid), 128'(0));
    check("rst_rom_start", 128'(rom_start), 128'(0));
    check("rst_rom_wr_en", 128'(rom_wr_en), 128'(0));
    check("rst_seq_done", 128'(seq_done), 128'(0));
    check("rst_rom_sel", 128'(rom_sel), 128'(0));
    check("rst_key_round", 128'(key_round), 128'(0));
    check("rst_key_out", key_out, 128'(0));
    repeat (3) step();
    resetn = 1'b1;
    repeat (2) step();
    samp();
    check("idle_no_start", 128'(busy), 128'(0));

    // Full sequences, both orders; the second with start/decrypt glitches mid-run.
    run_full(1'b0, 1'b0);
    run_full(1'b1, 1'b1);

    // Backpressure on key 2 with a stray rom_done while presenting.
    q_round.delete();
    q_key.delete();
    base_done = n_done;
    rs9       = 0;
    start_seq(1'b0);
    while (c <= 15) begin
      key_ready = !(c >= 9 && c <= 13);
      if (c == 11) begin
        #2;
        rom_done = 1'b1;
        rom_data = JUNK_SPUR;
      end
      samp();
      if (c == 9) rs9 = n_rs;
      if (c >= 9 && c <= 14) begin
        check("bp_valid", 128'(key_valid), 128'(1));
        check("bp_round", 128'(key_round), 128'(2));
        check("bp_key", key_out, rom_word(2));
      end
      if (c == 14) check("bp_no_strobe", 128'(n_rs - rs9), 128'(0));
      if (c == 15) begin
        check("bp_valid_fall", 128'(key_valid), 128'(0));
        check("bp_next_req", 128'(rom_start), 128'(1));
        check("bp_next_sel", 128'(rom_sel), 128'(3));
      end
      step();
    end
    key_ready = 1'b1;
    wait_done(base_done);
    check_queue(1'b0);

    // ROM answering four cycles after each strobe.
    q_round.delete();
    q_key.delete();
    rom_dly   = 4;
    base_rs   = n_rs;
    base_done = n_done;
    start_seq(1'b0);
    while (c <= 6) begin
      samp();
      check("stall_valid", 128'(key_valid), 128'(c == 6));
      check("stall_rom_start", 128'(rom_start), 128'(c == 1));
      check("stall_busy", 128'(busy), 128'(1));
      if (c == 6) begin
        check("stall_round", 128'(key_round), 128'(0));
        check("stall_key", key_out, rom_word(0));
      end
      step();
    end
    wait_done(base_done);
    check("stall_strobes", 128'(n_rs - base_rs), 128'(15));
    check_queue(1'b0);
    rom_dly = 1;

    // Abort while key 7 is presented.
    base_done = n_done;
    start_seq(1'b0);
    repeat (23) step();
    abort = 1'b1;
    samp();
    check("ab_pre_valid", 128'(key_valid), 128'(1));
    check("ab_pre_round", 128'(key_round), 128'(7));
    step();
    abort = 1'b0;
    samp();
    check("ab_busy", 128'(busy), 128'(0));
    check("ab_valid", 128'(key_valid), 128'(0));
    check("ab_seq_done", 128'(seq_done), 128'(0));
    check("ab_key_out", key_out, rom_word(7));
    check("ab_rom_start", 128'(rom_start), 128'(0));
    repeat (2) step();
    check("ab_no_done", 128'(n_done - base_done), 128'(0));
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    samp();
    check("ab_start_idle", 128'(busy), 128'(0));
    base_done = n_done;
    start_seq(1'b0);
    samp();
    check("ab_restart_strobe", 128'(rom_start), 128'(1));
    check("ab_restart_sel", 128'(rom_sel), 128'(0));
    step();
    step();
    samp();
    check("ab_restart_valid", 128'(key_valid), 128'(1));
    check("ab_restart_round", 128'(key_round), 128'(0));
    wait_done(base_done);

    // Asynchronous reset during WAIT of a decrypt sequence.
    start_seq(1'b1);
    step();
    #1 resetn = 1'b0;
    #1;
    check("ar_busy", 128'(busy), 128'(0));
    check("ar_valid", 128'(key_valid), 128'(0));
    check("ar_rom_start", 128'(rom_start), 128'(0));
    check("ar_rom_wr_en", 128'(rom_wr_en), 128'(0));
    check("ar_seq_done", 128'(seq_done), 128'(0));
    check("ar_key_out", key_out, 128'(0));
    check("ar_key_round", 128'(key_round), 128'(0));
    check("ar_rom_sel", 128'(rom_sel), 128'(0));
    step();
    resetn = 1'b1;
    step();
    run_full(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
